programacion_ctrl: RTL and testbench

Downstream consumer of the Switches stage's 2-bit `programacion` mode code (00 normal, 01 time, 10 date, 11 timer).
- On entry to a programming mode, captures the current RTC values for that mode.
- Lets the user edit three BCD fields with cursor and up/down button pulses.
- On exit, commits the edited fields to the RTC bus controller through a req/ack handshake.
- Drives the display path with the edited fields and the cursor position.

---
 rtl/programacion_pkg.sv | 35 +++
 rtl/bcd_field_step.sv | 40 ++++
 rtl/programacion_ctrl.sv | 141 ++++++++++++++
 tb/tb_programacion_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/programacion_pkg.sv
// Shared definitions for the programming-mode controller.
//   - Mode codes as delivered by the Switches stage.
//   - Controller state encoding.
//   - Per-mode, per-field BCD limit tables, indexed [mode][field].
package programacion_pkg;

  localparam logic [1:0] MODO_NORMAL = 2'b00;
  localparam logic [1:0] MODO_HORA   = 2'b01;
  localparam logic [1:0] MODO_FECHA  = 2'b10;
  localparam logic [1:0] MODO_TIMER  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EDIT  = 2'b01,
    WRITE = 2'b10
  } state_t;

  // Leftmost entry is mode 3 (timer), rightmost is mode 0 (normal).
  // Inside each mode: '{field2, field1, field0}.
  // Normal mode is never captured, so its limits are only placeholders.
  localparam logic [3:0][2:0][7:0] FIELD_MIN = '{
    '{8'h00, 8'h00, 8'h00},   // timer: hh mm ss
    '{8'h00, 8'h01, 8'h01},   // date:  yy mm dd
    '{8'h00, 8'h00, 8'h00},   // time:  hh mm ss
    '{8'h00, 8'h00, 8'h00}    // normal
  };

  localparam logic [3:0][2:0][7:0] FIELD_MAX = '{
    '{8'h23, 8'h59, 8'h59},
    '{8'h99, 8'h12, 8'h31},
    '{8'h23, 8'h59, 8'h59},
    '{8'h00, 8'h00, 8'h00}
  };

endpackage

// File: rtl/bcd_field_step.sv
// Combinational BCD step for one editable field.
// Ports:
//   val        current field value (BCD)
//   fmin/fmax  inclusive limits for this field in the active mode
//   up/down    step request; both or neither leave the value as is
//   nxt        next value: wraps max->min / min->max, and any value that is
//              not valid BCD or lies outside [fmin, fmax] becomes fmin
module bcd_field_step (
  input  logic [7:0] val,
  input  logic [7:0] fmin,
  input  logic [7:0] fmax,
  input  logic       up,
  input  logic       down,
  output logic [7:0] nxt
);

  logic [3:0] hi;
  logic [3:0] lo;
  logic       valid;

  assign hi = val[7:4];
  assign lo = val[3:0];

  always_comb begin
    valid = (hi <= 4'd9) && (lo <= 4'd9) && (val >= fmin) && (val <= fmax);
    nxt   = val;
    if (!valid) begin
      nxt = fmin;
    end else if (up && !down) begin
      if (val == fmax)       nxt = fmin;
      else if (lo == 4'd9)   nxt = {hi + 4'd1, 4'd0};
      else                   nxt = {hi, lo + 4'd1};
    end else if (down && !up) begin
      if (val == fmin)       nxt = fmax;
      else if (lo == 4'd0)   nxt = {hi - 4'd1, 4'd9};
      else                   nxt = {hi, lo - 4'd1};
    end
  end

endmodule

// File: rtl/programacion_ctrl.sv
// Programming-mode controller: captures RTC values when a programming mode
// is selected, lets the user edit three BCD fields, and commits them to the
// RTC bus controller with a req/ack handshake when the mode is left.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   programacion                mode code (00 normal, 01 time, 10 date, 11 timer)
//   btn_up/down/left/right      single-cycle debounced button pulses
//   cur_f0..cur_f2              current RTC values for the requested mode
//   wr_ack                      write acknowledge from the RTC bus controller
//   campo0..campo2              fields being edited (to display)
//   cursor                      selected field 0..2
//   editando                    high while editing
//   wr_req, wr_sel, wr_data     write request, mode written, {campo2,campo1,campo0}
//   wr_err                      one-cycle pulse when the ack never arrives
module programacion_ctrl
  import programacion_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int CNT_W       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  programacion,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [7:0]  cur_f0,
  input  logic [7:0]  cur_f1,
  input  logic [7:0]  cur_f2,
  input  logic        wr_ack,
  output logic [7:0]  campo0,
  output logic [7:0]  campo1,
  output logic [7:0]  campo2,
  output logic [1:0]  cursor,
  output logic        editando,
  output logic        wr_req,
  output logic [1:0]  wr_sel,
  output logic [23:0] wr_data,
  output logic        wr_err
);

  state_t            state;
  logic [1:0]        mode_reg;
  logic              dirty;
  logic [CNT_W-1:0]  cnt;
  logic [2:0][7:0]   campo;
  logic [2:0][7:0]   cur;
  logic [2:0][7:0]   nxt;
  logic [1:0]        sel_mode;
  logic              leaving;
  logic              edit_ok;

  assign cur      = {cur_f2, cur_f1, cur_f0};
  // While idle the steppers act as a pure clamp on the captured values,
  // using the limits of the mode being entered.
  assign sel_mode = (state == IDLE) ? programacion : mode_reg;
  assign leaving  = (state == EDIT) && (programacion != mode_reg);
  assign edit_ok  = (state == EDIT) && !leaving;

  for (genvar i = 0; i < 3; i++) begin : g_field
    bcd_field_step u_step (
      .val  ((state == IDLE) ? cur[i] : campo[i]),
      .fmin (FIELD_MIN[sel_mode][i]),
      .fmax (FIELD_MAX[sel_mode][i]),
      .up   (edit_ok && btn_up   && (cursor == 2'(i))),
      .down (edit_ok && btn_down && (cursor == 2'(i))),
      .nxt  (nxt[i])
    );
  end

  assign campo0  = campo[0];
  assign campo1  = campo[1];
  assign campo2  = campo[2];
  assign wr_data = {campo[2], campo[1], campo[0]};
  assign wr_sel  = wr_req ? mode_reg : MODO_NORMAL;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      campo    <= '0;
      cursor   <= 2'd0;
      mode_reg <= MODO_NORMAL;
      dirty    <= 1'b0;
      cnt      <= '0;
      editando <= 1'b0;
      wr_req   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          editando <= 1'b0;
          if (programacion != MODO_NORMAL) begin
            campo    <= nxt;
            mode_reg <= programacion;
            cursor   <= 2'd0;
            dirty    <= 1'b0;
            editando <= 1'b1;
            state    <= EDIT;
          end
        end
        EDIT: begin
          if (leaving) begin
            editando <= 1'b0;
            if (dirty) begin
              wr_req <= 1'b1;
              cnt    <= '0;
              state  <= WRITE;
            end else begin
              state  <= IDLE;
            end
          end else begin
            campo <= nxt;
            if (btn_up ^ btn_down) dirty <= 1'b1;
            if (btn_right && !btn_left)
              cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
            else if (btn_left && !btn_right)
              cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            wr_req <= 1'b0;
            wr_err <= 1'b1;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_programacion_ctrl.sv
module tb_programacion_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  programacion;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [7:0]  cur_f0, cur_f1, cur_f2;
  logic        wr_ack;
  logic [7:0]  campo0, campo1, campo2;
  logic [1:0]  cursor;
  logic        editando;
  logic        wr_req;
  logic [1:0]  wr_sel;
  logic [23:0] wr_data;
  logic        wr_err;

  int vectors = 0;
  int miscompares = 0;

  programacion_ctrl #(.ACK_TIMEOUT(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .programacion(programacion),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .cur_f0(cur_f0), .cur_f1(cur_f1), .cur_f2(cur_f2), .wr_ack(wr_ack),
    .campo0(campo0), .campo1(campo1), .campo2(campo2), .cursor(cursor),
    .editando(editando), .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic u, input logic d, input logic l, input logic r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    step();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  initial begin
    int  n;
    logic seen;
    reset = 0; programacion = 2'b00; wr_ack = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    cur_f0 = 8'h59; cur_f1 = 8'h59; cur_f2 = 8'h23;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_campo", {8'h0, wr_data}, 32'h0);
    chk("rst_ctrl", {cursor, editando, wr_req, wr_sel, wr_err}, 32'h0);
    reset = 1;
    step();
    chk("idle_no_edit", editando, 0);

    // Load and increment in time mode
    programacion = 2'b01;
    step();
    chk("t_editando", editando, 1);
    chk("t_load", wr_data, 24'h235959);
    chk("t_cursor0", cursor, 0);
    pulse(1, 0, 0, 0);
    chk("t_up_wrap_ss", wr_data, 24'h235900);
    pulse(0, 0, 1, 0);
    chk("t_left_wrap", cursor, 2);
    pulse(1, 0, 0, 0);
    chk("t_up_wrap_hh", wr_data, 24'h005900);

    // Commit on exit, ack after 3 cycles of request
    programacion = 2'b00;
    step();
    chk("c_req", {wr_req, editando, wr_sel}, {1'b1, 1'b0, 2'b01});
    chk("c_data", wr_data, 24'h005900);
    step();
    step();
    chk("c_hold", {wr_req, wr_sel, wr_data}, {1'b1, 2'b01, 24'h005900});
    wr_ack = 1;
    step();
    wr_ack = 0;
    chk("c_ack_drop", {wr_req, wr_sel, wr_err}, 0);
    step();
    chk("c_idle", {editando, wr_req}, 0);

    // Date mode: decrement wraps and cursor handling
    cur_f0 = 8'h01; cur_f1 = 8'h01; cur_f2 = 8'h24;
    programacion = 2'b10;
    step();
    chk("d_load", wr_data, 24'h240101);
    pulse(0, 1, 0, 0);
    chk("d_dd_wrap", campo0, 8'h31);
    pulse(0, 0, 0, 1);
    chk("d_cursor1", cursor, 1);
    pulse(0, 1, 0, 0);
    chk("d_mm_wrap", campo1, 8'h12);
    pulse(1, 1, 0, 0);
    chk("d_updown_same", campo1, 8'h12);
    pulse(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    chk("d_left_wrap", cursor, 2);
    pulse(1, 0, 1, 0);
    chk("d_up_and_left", {campo2, 6'b0, cursor}, {8'h25, 8'd1});
    pulse(0, 0, 1, 1);
    chk("d_lr_same", cursor, 1);
    programacion = 2'b00;
    step();
    chk("d_write", {wr_req, wr_sel, wr_data}, {1'b1, 2'b10, 24'h251231});
    wr_ack = 1;
    step();
    wr_ack = 0;
    chk("d_ack", wr_req, 0);

    // Ack outside WRITE is ignored
    wr_ack = 1;
    step();
    wr_ack = 0;
    chk("ack_idle", {editando, wr_req, wr_err}, 0);

    // Timer mode with no edits: no write
    cur_f0 = 8'h10; cur_f1 = 8'h20; cur_f2 = 8'h05;
    programacion = 2'b11;
    step();
    chk("n_load", wr_data, 24'h052010);
    programacion = 2'b00;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | wr_req;
    end
    chk("n_no_req", {seen, editando}, 0);

    // Invalid and out-of-range capture in time mode, then timeout
    cur_f0 = 8'h60; cur_f1 = 8'h7A; cur_f2 = 8'h24;
    programacion = 2'b01;
    step();
    chk("i_clamp", wr_data, 24'h000000);
    pulse(0, 1, 0, 0);
    chk("i_ss_down", campo0, 8'h59);
    programacion = 2'b00;
    step();
    chk("to_req", wr_req, 1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wr_req) n++;
      else break;
    end
    chk("to_len", n, 8);
    chk("to_err", {wr_err, wr_req}, 2'b10);
    step();
    chk("to_err_1cyc", wr_err, 0);

    // Direct mode switch 01 -> 10 with edits
    cur_f0 = 8'h12; cur_f1 = 8'h34; cur_f2 = 8'h05;
    programacion = 2'b01;
    step();
    pulse(1, 0, 0, 0);
    chk("m_edit", campo0, 8'h13);
    cur_f0 = 8'h15; cur_f1 = 8'h06; cur_f2 = 8'h24;
    programacion = 2'b10;
    step();
    chk("m_write", {wr_req, wr_sel, wr_data}, {1'b1, 2'b01, 24'h053413});
    wr_ack = 1;
    step();
    wr_ack = 0;
    chk("m_ack", {wr_req, editando}, 0);
    step();
    chk("m_reload", {editando, wr_data}, {1'b1, 24'h240615});

    // Asynchronous reset during WRITE
    pulse(1, 0, 0, 0);
    programacion = 2'b00;
    step();
    chk("r_req", wr_req, 1);
    #2 reset = 0;
    #1;
    chk("r_async", {wr_req, editando, cursor, wr_sel, wr_data}, 0);
    #2 reset = 1;
    step();
    chk("r_after", {wr_req, editando, wr_err}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
